spi_frame_ctrl: RTL and testbench

Frame-level controller for the SPI slave byte receiver. It synchronises chip select, holds the receiver in reset between frames, and parses each CS-framed byte stream: a header byte carrying a write command and start address, followed by data bytes. Each data byte becomes one write on a valid/ready register-bus port, with address auto-increment. The block sits between the byte receiver (its `finish`/`out` pair) and the register file.

---
 rtl/spi_frame_ctrl.sv | 153 +++++++++++++++
 tb/tb_spi_frame_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_ctrl.sv
// Frame controller for the SPI slave byte receiver: synchronises chip select,
// parses header + data bytes per frame and drives a one-entry register write port.
module spi_frame_ctrl #(
  parameter int ADDR_W    = 7,
  parameter int MAX_BURST = 16
) (
  input  logic              iclk,
  input  logic              rstn,
  input  logic              cs_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_rstn,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              frame_done,
  output logic [7:0]        last_len,
  output logic              err_cmd,
  output logic              err_burst,
  output logic              err_ovf
);

  typedef enum logic [1:0] {IDLE, HDR, DATA, DISCARD} state_t;

  localparam logic [7:0] BURST_LIM = 8'(MAX_BURST);

  state_t            state, state_nx;
  logic              cs_m, cs_s, cs_d;
  logic              frame_start, frame_end;
  logic [ADDR_W-1:0] addr_cnt;
  logic [7:0]        len_cnt, len_nx;
  logic              hdr_load, len_clr, wr_load;
  logic              cmd_bad, burst_bad, ovf, done;

  // chip select synchroniser; cs_d is the previous synchronised level for edge detect
  always_ff @(posedge iclk or negedge rstn) begin
    if (!rstn) begin
      cs_m    <= 1'b1;
      cs_s    <= 1'b1;
      cs_d    <= 1'b1;
      rx_rstn <= 1'b0;
    end else begin
      cs_m    <= cs_n;
      cs_s    <= cs_m;
      cs_d    <= cs_s;
      rx_rstn <= ~cs_s;
    end
  end

  assign frame_start = cs_d & ~cs_s;
  assign frame_end   = ~cs_d & cs_s;

  always_ff @(posedge iclk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    hdr_load  = 1'b0;
    len_clr   = 1'b0;
    wr_load   = 1'b0;
    cmd_bad   = 1'b0;
    burst_bad = 1'b0;
    ovf       = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (frame_start) begin
          state_nx = HDR;
          len_clr  = 1'b1;
        end
      end
      HDR: begin
        if (rx_valid) begin
          if (rx_data[7]) begin
            hdr_load = 1'b1;
            state_nx = DATA;
          end else begin
            cmd_bad  = 1'b1;
            state_nx = DISCARD;
          end
        end
      end
      DATA: begin
        if (rx_valid) begin
          if (len_cnt >= BURST_LIM) begin
            burst_bad = 1'b1;
            state_nx  = DISCARD;
          end else if (wr_valid && !wr_ready) begin
            ovf = 1'b1;
          end else begin
            wr_load = 1'b1;
          end
        end
      end
      default: ;
    endcase
    // a byte coinciding with frame end is handled above first; a header byte
    // arriving in that same cycle still counts as a header for frame_done
    if (frame_end && (state != IDLE)) begin
      state_nx = IDLE;
      done     = (state != HDR) || rx_valid;
    end
    len_nx = len_cnt;
    if (len_clr || hdr_load) len_nx = '0;
    else if (wr_load)        len_nx = len_cnt + 8'd1;
  end

  always_ff @(posedge iclk or negedge rstn) begin
    if (!rstn) begin
      addr_cnt <= '0;
      len_cnt  <= '0;
    end else begin
      len_cnt <= len_nx;
      if (hdr_load)     addr_cnt <= rx_data[ADDR_W-1:0];
      else if (wr_load) addr_cnt <= addr_cnt + ADDR_W'(1);
    end
  end

  // one-entry write buffer; it outlives the frame so a stalled write still completes
  always_ff @(posedge iclk or negedge rstn) begin
    if (!rstn) begin
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else if (wr_load) begin
      wr_valid <= 1'b1;
      wr_addr  <= addr_cnt;
      wr_data  <= rx_data;
    end else if (wr_ready) begin
      wr_valid <= 1'b0;
    end
  end

  always_ff @(posedge iclk or negedge rstn) begin
    if (!rstn) begin
      frame_done <= 1'b0;
      last_len   <= '0;
      err_cmd    <= 1'b0;
      err_burst  <= 1'b0;
      err_ovf    <= 1'b0;
    end else begin
      frame_done <= done;
      err_cmd    <= cmd_bad;
      err_burst  <= burst_bad;
      err_ovf    <= ovf;
      if (done) last_len <= len_nx;
    end
  end

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Randomised and directed bench for spi_frame_ctrl against a frame-level model.
module tb_spi_frame_ctrl;
  localparam int ADDR_W    = 7;
  localparam int MAX_BURST = 16;

  logic              iclk = 1'b0;
  logic              rstn = 1'b0;
  logic              cs_n = 1'b1;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              wr_ready = 1'b1;
  logic              rx_rstn, wr_valid, frame_done, err_cmd, err_burst, err_ovf;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data, last_len;

  spi_frame_ctrl #(.ADDR_W(ADDR_W), .MAX_BURST(MAX_BURST)) dut (
    .iclk(iclk), .rstn(rstn), .cs_n(cs_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_rstn(rx_rstn), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .frame_done(frame_done), .last_len(last_len),
    .err_cmd(err_cmd), .err_burst(err_burst), .err_ovf(err_ovf)
  );

  always #5 iclk = ~iclk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: byte index within the frame decides its meaning,
  // write address is base + accepted count modulo 2^ADDR_W.
  bit         hist [3] = '{1'b1, 1'b1, 1'b1};
  bit         m_in = 0, m_hdr_ok = 0, m_stop = 0, m_was_in, fs, fe, take;
  int         m_nb = 0, m_cnt = 0;
  logic [6:0] m_base = '0;
  bit         e_pend = 0, e_done = 0, e_cmd = 0, e_burst = 0, e_ovf = 0, e_rxr = 0;
  logic [6:0] e_addr = '0;
  logic [7:0] e_data = '0, e_last = '0;

  always @(posedge iclk or negedge rstn) begin
    if (!rstn) begin
      hist = '{1'b1, 1'b1, 1'b1};
      m_in = 0; m_hdr_ok = 0; m_stop = 0; m_nb = 0; m_cnt = 0; m_base = '0;
      e_pend = 0; e_done = 0; e_cmd = 0; e_burst = 0; e_ovf = 0; e_rxr = 0;
      e_addr = '0; e_data = '0; e_last = '0;
    end else begin
      fs = hist[2] && !hist[1];
      fe = !hist[2] && hist[1];
      m_was_in = m_in;
      take = 0;
      e_done = 0; e_cmd = 0; e_burst = 0; e_ovf = 0;
      if (m_was_in && rx_valid) begin
        if (m_nb == 0) begin
          if (rx_data[7]) begin m_hdr_ok = 1; m_base = rx_data[6:0]; end
          else e_cmd = 1;
        end else if (m_hdr_ok && !m_stop) begin
          if (m_cnt >= MAX_BURST) begin e_burst = 1; m_stop = 1; end
          else if (e_pend && !wr_ready) e_ovf = 1;
          else begin
            take = 1;
            e_addr = 7'((int'(m_base) + m_cnt) % 128);
            e_data = rx_data;
            m_cnt++;
          end
        end
        m_nb++;
      end
      if (take) e_pend = 1;
      else if (e_pend && wr_ready) e_pend = 0;
      if (m_was_in && fe) begin
        m_in = 0;
        if (m_nb > 0) begin e_done = 1; e_last = 8'(m_cnt); end
      end
      if (!m_was_in && fs) begin
        m_in = 1; m_nb = 0; m_cnt = 0; m_hdr_ok = 0; m_stop = 0;
      end
      hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = cs_n;
      e_rxr = !hist[2];
    end
  end

  always @(negedge iclk) begin
    chk("rx_rstn", 32'(rx_rstn), 32'(e_rxr));
    chk("wr_valid", 32'(wr_valid), 32'(e_pend));
    chk("wr_addr", 32'(wr_addr), 32'(e_addr));
    chk("wr_data", 32'(wr_data), 32'(e_data));
    chk("frame_done", 32'(frame_done), 32'(e_done));
    chk("last_len", 32'(last_len), 32'(e_last));
    chk("err_cmd", 32'(err_cmd), 32'(e_cmd));
    chk("err_burst", 32'(err_burst), 32'(e_burst));
    chk("err_ovf", 32'(err_ovf), 32'(e_ovf));
  end

  // observation log for the hand-computed directed expectations
  logic [14:0] wlog [$];
  int n_cmd = 0, n_burst = 0, n_ovf = 0, n_done = 0;
  logic [7:0] seen_len = '0;

  always @(posedge iclk) begin
    if (rstn) begin
      if (wr_valid && wr_ready) wlog.push_back({wr_addr, wr_data});
      if (err_cmd)   n_cmd++;
      if (err_burst) n_burst++;
      if (err_ovf)   n_ovf++;
      if (frame_done) begin n_done++; seen_len = last_len; end
    end
  end

  bit rand_rdy = 0;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge iclk);
      #1;
      if (rand_rdy) wr_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic clear_log();
    wlog.delete();
    n_cmd = 0; n_burst = 0; n_ovf = 0; n_done = 0; seen_len = '0;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    rx_valid = 1'b1;
    rx_data  = b;
    tick(1);
    rx_valid = 1'b0;
    tick(gap);
  endtask

  task automatic cs_low();
    cs_n = 1'b0;
    tick(4);
  endtask

  task automatic cs_high();
    cs_n = 1'b1;
    tick(6);
  endtask

  task automatic chk_write(input string name, input int idx, input logic [6:0] a, input logic [7:0] d);
    if (idx < wlog.size()) chk(name, 32'(wlog[idx]), 32'({a, d}));
    else chk(name, 32'hFFFF_FFFF, 32'({a, d}));
  endtask

  initial begin
    logic [7:0] b;
    int nb;
    tick(2);
    chk("reset_rx_rstn", 32'(rx_rstn), 0);
    chk("reset_wr_valid", 32'(wr_valid), 0);
    rstn = 1'b1;
    tick(3);

    // basic write
    clear_log();
    cs_low();
    send(8'h85, 2); send(8'h11, 2); send(8'h22, 2); send(8'h33, 2);
    cs_high();
    chk("basic_nwr", wlog.size(), 3);
    chk_write("basic_w0", 0, 7'h05, 8'h11);
    chk_write("basic_w1", 1, 7'h06, 8'h22);
    chk_write("basic_w2", 2, 7'h07, 8'h33);
    chk("basic_done", n_done, 1);
    chk("basic_len", 32'(seen_len), 3);
    chk("basic_errs", n_cmd + n_burst + n_ovf, 0);

    // address wrap
    clear_log();
    cs_low();
    send(8'hFE, 1); send(8'hAA, 1); send(8'hBB, 1); send(8'hCC, 1);
    cs_high();
    chk_write("wrap_w0", 0, 7'h7E, 8'hAA);
    chk_write("wrap_w1", 1, 7'h7F, 8'hBB);
    chk_write("wrap_w2", 2, 7'h00, 8'hCC);

    // unsupported command
    clear_log();
    cs_low();
    send(8'h12, 2); send(8'h01, 2); send(8'h02, 2);
    cs_high();
    chk("badcmd_err", n_cmd, 1);
    chk("badcmd_nwr", wlog.size(), 0);
    chk("badcmd_done", n_done, 1);
    chk("badcmd_len", 32'(seen_len), 0);

    // burst limit
    clear_log();
    cs_low();
    send(8'h80, 1);
    for (int i = 0; i < 18; i++) send(8'(8'h40 + i), 1);
    cs_high();
    chk("burst_nwr", wlog.size(), 16);
    for (int i = 0; i < 16; i++) chk_write("burst_w", i, 7'(i), 8'(8'h40 + i));
    chk("burst_err", n_burst, 1);
    chk("burst_len", 32'(seen_len), 16);

    // backpressure
    clear_log();
    wr_ready = 1'b0;
    cs_low();
    send(8'h80, 2);
    send(8'h5A, 19);
    send(8'hA5, 19);
    chk("bp_hold_valid", 32'(wr_valid), 1);
    chk("bp_hold_addr", 32'(wr_addr), 0);
    chk("bp_hold_data", 32'(wr_data), 32'h5A);
    chk("bp_ovf", n_ovf, 1);
    wr_ready = 1'b1;
    tick(2);
    cs_high();
    chk("bp_nwr", wlog.size(), 1);
    chk_write("bp_w0", 0, 7'h00, 8'h5A);
    chk("bp_len", 32'(seen_len), 1);

    // asynchronous reset while a write is pending
    clear_log();
    wr_ready = 1'b0;
    cs_low();
    send(8'h90, 2); send(8'h77, 2);
    chk("rst_pre_valid", 32'(wr_valid), 1);
    rstn = 1'b0;
    #1;
    chk("rst_wr_valid", 32'(wr_valid), 0);
    chk("rst_wr_addr", 32'(wr_addr), 0);
    chk("rst_rx_rstn", 32'(rx_rstn), 0);
    chk("rst_last_len", 32'(last_len), 0);
    tick(1);
    rstn = 1'b1;
    cs_n = 1'b1;
    wr_ready = 1'b1;
    tick(6);
    chk("rst_no_done", n_done, 0);
    chk("rst_nwr", wlog.size(), 0);

    // CS abort with no complete byte, then a clean frame
    clear_log();
    cs_low();
    cs_n = 1'b1;
    tick(3);
    chk("abort_rx_rstn", 32'(rx_rstn), 0);
    tick(3);
    cs_low();
    send(8'h83, 2); send(8'h44, 2);
    cs_high();
    chk_write("abort_w0", 0, 7'h03, 8'h44);
    chk("abort_len", 32'(seen_len), 1);

    // randomised frames with random write-port backpressure
    for (int f = 0; f < 40; f++) begin
      rand_rdy = 1;
      cs_low();
      nb = $urandom_range(0, 20);
      for (int i = 0; i < nb; i++) begin
        b = 8'($urandom_range(0, 255));
        if (i == 0) b = ($urandom_range(0, 4) == 0) ? (b & 8'h7F) : (b | 8'h80);
        send(b, $urandom_range(0, 3));
      end
      cs_n = 1'b1;
      if ($urandom_range(0, 1) == 1) begin
        tick($urandom_range(0, 3));
        send(8'($urandom_range(0, 255)), 0);
      end
      tick(6);
      rand_rdy = 0;
      wr_ready = 1'b1;
      tick(2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
